// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: frame-synchronous double buffering,
// per-digit enable/dp, leading-zero blanking, PWM dimming and a frame tick.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 100000,
  parameter int BRIGHT_W       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_suppress,
  input  logic [BRIGHT_W-1:0]     brightness,
  input  logic                    load,
  output logic [6:0]              segments,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOT  = REFRESH_DIV >> BRIGHT_W;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? '1 : '0;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    s = 7'h00;
    case (h)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        dwell_cnt, dwell_next;
  logic [CNT_W-1:0]        slot_cnt, slot_next;
  logic [BRIGHT_W-1:0]     phase, phase_next;
  logic [IDX_W-1:0]        digit_idx, idx_next;
  logic [4*NUM_DIGITS-1:0] pend_value, act_value, act_value_next;
  logic [NUM_DIGITS-1:0]   pend_dp, pend_en, act_dp, act_en, act_dp_next, act_en_next;
  logic                    pending_valid, pending_valid_next;
  logic                    dwell_wrap, frame_wrap;

  always_comb begin
    dwell_wrap         = (dwell_cnt == DWELL_LAST);
    frame_wrap         = dwell_wrap && (digit_idx == IDX_LAST);
    dwell_next         = dwell_wrap ? '0 : dwell_cnt + CNT_W'(1);
    slot_next          = slot_cnt + CNT_W'(1);
    phase_next         = phase;
    idx_next           = digit_idx;
    act_value_next     = act_value;
    act_dp_next        = act_dp;
    act_en_next        = act_en;
    pending_valid_next = pending_valid;

    // Slot/phase counters replace dwell_cnt / SLOT so no divider is built.
    if (dwell_wrap) begin
      slot_next  = '0;
      phase_next = '0;
      idx_next   = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
    end else if (slot_cnt == SLOT_LAST) begin
      slot_next  = '0;
      phase_next = phase + BRIGHT_W'(1);
    end

    if (frame_wrap && pending_valid) begin
      act_value_next     = pend_value;
      act_dp_next        = pend_dp;
      act_en_next        = pend_en;
      pending_valid_next = 1'b0;
    end
    if (load) pending_valid_next = 1'b1;
  end

  // Output decode works on next-state values so the registered outputs line up
  // with the state: a new digit shows on the cycle right after its wrap.
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] zero_from, blank;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign nib[gi] = act_value_next[4*gi +: 4];
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign zero_from[gi] = (nib[gi] == 4'h0);
    end else begin : g_low
      assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
    end
    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_msd
      assign blank[gi] = lz_suppress && zero_from[gi];
    end
  end

  logic                  sel_en, sel_dp, sel_blank, pwm_lit, an_on, dp_on;
  logic [6:0]            seg_on;
  logic [NUM_DIGITS-1:0] an_vec;

  always_comb begin
    sel_en    = act_en_next[idx_next];
    sel_dp    = act_dp_next[idx_next];
    sel_blank = blank[idx_next];
    pwm_lit   = (phase_next < brightness) || (&brightness);
    seg_on    = (sel_en && !sel_blank) ? hex_to_seg(nib[idx_next]) : 7'h00;
    dp_on     = sel_en && sel_dp;
    // A suppressed digit still lights its anode when it has a dp to show.
    an_on     = sel_en && pwm_lit && (!sel_blank || sel_dp);
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_vec[gi] = an_on && (idx_next == IDX_W'(gi));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dwell_cnt     <= '0;
      slot_cnt      <= '0;
      phase         <= '0;
      digit_idx     <= '0;
      pend_value    <= '0;
      pend_dp       <= '0;
      act_value     <= '0;
      act_dp        <= '0;
      // Enables come up set so an unloaded display reads as all zeros.
      pend_en       <= '1;
      act_en        <= '1;
      pending_valid <= 1'b0;
      segments      <= SEG_OFF;
      dp            <= DP_OFF;
      anodes        <= AN_OFF;
      frame_tick    <= 1'b0;
    end else begin
      dwell_cnt     <= dwell_next;
      slot_cnt      <= slot_next;
      phase         <= phase_next;
      digit_idx     <= idx_next;
      act_value     <= act_value_next;
      act_dp        <= act_dp_next;
      act_en        <= act_en_next;
      pending_valid <= pending_valid_next;
      if (load) begin
        pend_value <= value;
        pend_dp    <= dp_in;
        pend_en    <= digit_en;
      end
      segments   <= SEG_ACTIVE_LOW ? ~seg_on : seg_on;
      dp         <= SEG_ACTIVE_LOW ? ~dp_on : dp_on;
      anodes     <= AN_ACTIVE_LOW ? ~an_vec : an_vec;
      frame_tick <= frame_wrap;
    end
  end

endmodule
